// File: rtl/fp_accumulate_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fp_accumulate_ctrl
// Purpose  : Initiator-side sequencer for an external stb/ack float32 adder.
//            Reduces LEN elements of the incoming product stream into a
//            single sum and hands it to the result store.
// Ports    : clk, rst            clock / asynchronous active-high reset
//            in_data/_stb/_ack   element stream from upstream
//            add_a/_stb/_ack     running sum to adder input_a
//            add_b/_stb/_ack     new element to adder input_b
//            add_z/_stb/_ack     adder result back into the accumulator
//            sum_z/_stb/_ack     completed sum to downstream
// Options  : ACC_BYPASS_FIRST_EN - when defined, the first element of each
//            sum is loaded straight into the accumulator (no adder pass,
//            LEN-1 adder transactions per sum, sign of zero preserved).
//            When undefined, every element goes through the adder from a
//            +0.0 seed.
// Revision : 1.0 - initial release
// ============================================================================
module fp_accumulate_ctrl #(
    parameter int WIDTH = 32,
    parameter int LEN   = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_data_stb,
    output logic             in_data_ack,
    output logic [WIDTH-1:0] add_a,
    output logic             add_a_stb,
    input  logic             add_a_ack,
    output logic [WIDTH-1:0] add_b,
    output logic             add_b_stb,
    input  logic             add_b_ack,
    input  logic [WIDTH-1:0] add_z,
    input  logic             add_z_stb,
    output logic             add_z_ack,
    output logic [WIDTH-1:0] sum_z,
    output logic             sum_z_stb,
    input  logic             sum_z_ack
);

    localparam logic [1:0] c_st_get_in  = 2'd0;
    localparam logic [1:0] c_st_send    = 2'd1;
    localparam logic [1:0] c_st_wait_z  = 2'd2;
    localparam logic [1:0] c_st_put_sum = 2'd3;

    localparam logic [CNT_W-1:0] c_len = CNT_W'(LEN);

    logic [1:0]       r_state,       w_state_nxt;
    logic [WIDTH-1:0] r_acc,         w_acc_nxt;
    logic [CNT_W-1:0] r_cnt,         w_cnt_nxt;
    logic             r_in_data_ack, w_in_data_ack_nxt;
    logic [WIDTH-1:0] r_add_a,       w_add_a_nxt;
    logic             r_add_a_stb,   w_add_a_stb_nxt;
    logic [WIDTH-1:0] r_add_b,       w_add_b_nxt;
    logic             r_add_b_stb,   w_add_b_stb_nxt;
    logic             r_add_z_ack,   w_add_z_ack_nxt;
    logic [WIDTH-1:0] r_sum_z,       w_sum_z_nxt;
    logic             r_sum_z_stb,   w_sum_z_stb_nxt;

    logic             w_in_xfer;
    logic             w_a_xfer;
    logic             w_b_xfer;
    logic             w_z_xfer;
    logic             w_sum_xfer;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_last;
    logic             w_bypass;

    // Transfers are qualified by state so stray stb/ack levels from a peer
    // that is not being addressed cannot advance the sequence.
    assign w_in_xfer  = (r_state == c_st_get_in)  & in_data_stb & r_in_data_ack;
    assign w_a_xfer   = (r_state == c_st_send)    & r_add_a_stb & add_a_ack;
    assign w_b_xfer   = (r_state == c_st_send)    & r_add_b_stb & add_b_ack;
    assign w_z_xfer   = (r_state == c_st_wait_z)  & add_z_stb   & r_add_z_ack;
    assign w_sum_xfer = (r_state == c_st_put_sum) & r_sum_z_stb & sum_z_ack;

    assign w_cnt_inc  = r_cnt + 1'b1;
    assign w_last     = (w_cnt_inc == c_len);

`ifdef ACC_BYPASS_FIRST_EN
    // First element of a sum skips the adder and seeds the accumulator.
    assign w_bypass = (r_cnt == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_cnt_nxt         = r_cnt;
        w_in_data_ack_nxt = r_in_data_ack;
        w_add_a_nxt       = r_add_a;
        w_add_a_stb_nxt   = r_add_a_stb;
        w_add_b_nxt       = r_add_b;
        w_add_b_stb_nxt   = r_add_b_stb;
        w_add_z_ack_nxt   = r_add_z_ack;
        w_sum_z_nxt       = r_sum_z;
        w_sum_z_stb_nxt   = r_sum_z_stb;

        case (r_state)
            c_st_get_in: begin
                // Also raises ack on the first edge after reset release.
                w_in_data_ack_nxt = 1'b1;
                if (w_in_xfer) begin
                    if (w_bypass) begin
                        w_acc_nxt = in_data;
                        w_cnt_nxt = w_cnt_inc;
                        if (w_last) begin
                            w_in_data_ack_nxt = 1'b0;
                            w_sum_z_nxt       = in_data;
                            w_sum_z_stb_nxt   = 1'b1;
                            w_state_nxt       = c_st_put_sum;
                        end
                    end else begin
                        w_in_data_ack_nxt = 1'b0;
                        w_add_a_nxt       = r_acc;
                        w_add_b_nxt       = in_data;
                        w_add_a_stb_nxt   = 1'b1;
                        w_add_b_stb_nxt   = 1'b1;
                        w_state_nxt       = c_st_send;
                    end
                end
            end

            c_st_send: begin
                if (w_a_xfer) begin
                    w_add_a_stb_nxt = 1'b0;
                end
                if (w_b_xfer) begin
                    w_add_b_stb_nxt = 1'b0;
                end
                // Both operands delivered (earlier or on this edge).
                if ((!r_add_a_stb || w_a_xfer) && (!r_add_b_stb || w_b_xfer)) begin
                    w_add_z_ack_nxt = 1'b1;
                    w_state_nxt     = c_st_wait_z;
                end
            end

            c_st_wait_z: begin
                if (w_z_xfer) begin
                    w_add_z_ack_nxt = 1'b0;
                    w_acc_nxt       = add_z;
                    w_cnt_nxt       = w_cnt_inc;
                    if (w_last) begin
                        w_sum_z_nxt     = add_z;
                        w_sum_z_stb_nxt = 1'b1;
                        w_state_nxt     = c_st_put_sum;
                    end else begin
                        w_in_data_ack_nxt = 1'b1;
                        w_state_nxt       = c_st_get_in;
                    end
                end
            end

            c_st_put_sum: begin
                if (w_sum_xfer) begin
                    w_sum_z_stb_nxt   = 1'b0;
                    w_acc_nxt         = '0;
                    w_cnt_nxt         = '0;
                    w_in_data_ack_nxt = 1'b1;
                    w_state_nxt       = c_st_get_in;
                end
            end

            default: begin
                w_state_nxt = c_st_get_in;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_get_in;
            r_acc         <= '0;
            r_cnt         <= '0;
            r_in_data_ack <= 1'b0;
            r_add_a       <= '0;
            r_add_a_stb   <= 1'b0;
            r_add_b       <= '0;
            r_add_b_stb   <= 1'b0;
            r_add_z_ack   <= 1'b0;
            r_sum_z       <= '0;
            r_sum_z_stb   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_in_data_ack <= w_in_data_ack_nxt;
            r_add_a       <= w_add_a_nxt;
            r_add_a_stb   <= w_add_a_stb_nxt;
            r_add_b       <= w_add_b_nxt;
            r_add_b_stb   <= w_add_b_stb_nxt;
            r_add_z_ack   <= w_add_z_ack_nxt;
            r_sum_z       <= w_sum_z_nxt;
            r_sum_z_stb   <= w_sum_z_stb_nxt;
        end
    end

    assign in_data_ack = r_in_data_ack;
    assign add_a       = r_add_a;
    assign add_a_stb   = r_add_a_stb;
    assign add_b       = r_add_b;
    assign add_b_stb   = r_add_b_stb;
    assign add_z_ack   = r_add_z_ack;
    assign sum_z       = r_sum_z;
    assign sum_z_stb   = r_sum_z_stb;

endmodule
`default_nettype wire
